// File: rtl/ps2_ctrl_pkg.sv
// Shared types and scan-code constants for the PS/2 receive sequencer.
package ps2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_E0   = 3'd1,
    ST_PRE_F0   = 3'd2,
    ST_PRE_E0F0 = 3'd3,
    ST_RECOVER  = 3'd4
  } state_t;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_ACK  = 8'hFA;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  function automatic logic is_err(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_event_buf.sv
// One-entry key event buffer with valid/ack handshake and sticky overrun flag.
module ps2_event_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       emit,
  input  logic [7:0] ev_code,
  input  logic       ev_ext,
  input  logic       ev_brk,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  output logic       overrun
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_brk   <= 1'b0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (emit) begin
      // An ack in the same cycle frees the slot for the incoming event.
      if (!key_valid || key_ack) begin
        key_code  <= ev_code;
        key_ext   <= ev_ext;
        key_brk   <= ev_brk;
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive sequencer: scan-code prefix parser, inter-byte watchdog,
// receiver recovery reset and a one-entry key event buffer.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for first byte of a scan-code sequence
// ST_PRE_E0   | E0 seen, waiting for F0 or final code
// ST_PRE_F0   | F0 seen, waiting for final code
// ST_PRE_E0F0 | E0 F0 seen, waiting for final code
// ST_RECOVER  | receiver held in reset for RST_LEN cycles
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYC = 5000000,
  parameter int RST_LEN     = 16,
  parameter int CNT_W       = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       rx_en,
  output logic       rx_rst,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);
  import ps2_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             emit, ev_ext, ev_brk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      rx_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      rx_en   <= enable && (state_d != ST_RECOVER);
    end
  end

  // The watchdog counter doubles as the recovery-length timer.
  always_comb begin
    state_d = state_q;
    wdog_d  = '0;
    if (state_q == ST_RECOVER) begin
      if (wdog_q == RST_LAST) state_d = ST_IDLE;
      else                    wdog_d  = wdog_q + CNT_W'(1);
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if      (rx_dout == SC_EXT) state_d = ST_PRE_E0;
          else if (rx_dout == SC_BRK) state_d = ST_PRE_F0;
          else if (is_err(rx_dout))   state_d = ST_RECOVER;
        end
        ST_PRE_E0: begin
          if      (rx_dout == SC_BRK) state_d = ST_PRE_E0F0;
          else if (is_err(rx_dout))   state_d = ST_RECOVER;
          else                        state_d = ST_IDLE;
        end
        default: begin
          if (is_err(rx_dout) || is_prefix(rx_dout)) state_d = ST_RECOVER;
          else                                        state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (wdog_q == TO_LAST) state_d = ST_RECOVER;
      else                   wdog_d  = wdog_q + CNT_W'(1);
    end
  end

  always_comb begin
    rx_rst = (state_q == ST_RECOVER);
    emit   = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    if (enable && rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          emit = !(is_prefix(rx_dout) || is_err(rx_dout) ||
                   rx_dout == SC_BAT || rx_dout == SC_ACK);
        end
        ST_PRE_E0: begin
          emit   = !(rx_dout == SC_BRK || is_err(rx_dout));
          ev_ext = 1'b1;
        end
        ST_PRE_F0: begin
          emit   = !(is_err(rx_dout) || is_prefix(rx_dout));
          ev_brk = 1'b1;
        end
        ST_PRE_E0F0: begin
          emit   = !(is_err(rx_dout) || is_prefix(rx_dout));
          ev_ext = 1'b1;
          ev_brk = 1'b1;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  ps2_event_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .emit      (emit),
    .ev_code   (rx_dout),
    .ev_ext    (ev_ext),
    .ev_brk    (ev_brk),
    .key_ack   (key_ack),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_brk   (key_brk),
    .key_valid (key_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl with a scoreboard of expected key events.
module tb_ps2_rx_ctrl;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       key_ack = 1'b0;
  logic       rx_en, rx_rst, key_ext, key_brk, key_valid, overrun;
  logic [7:0] key_code;

  int  checks = 0;
  int  failures = 0;
  ev_t sb[$];

  always #5 clk = ~clk;

  ps2_rx_ctrl #(.TIMEOUT_CYC(100), .RST_LEN(16), .CNT_W(23)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_en        (rx_en),
    .rx_rst       (rx_rst),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_brk      (key_brk),
    .key_valid    (key_valid),
    .key_ack      (key_ack),
    .overrun      (overrun)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle tick; returns on the negedge after the capturing edge.
  task automatic send_byte(input logic [7:0] b, input logic ack);
    @(negedge clk);
    rx_dout = b;
    rx_done_tick = 1'b1;
    key_ack = ack;
    @(negedge clk);
    rx_done_tick = 1'b0;
    key_ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // Scoreboard consumer: the buffered event must match the oldest expectation.
  task automatic sb_pop(input string name);
    ev_t exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: event seen but scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      if ({key_valid, key_code, key_ext, key_brk} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL %s: got valid=%b code=%h ext=%b brk=%b, want valid=1 code=%h ext=%b brk=%b",
                 name, key_valid, key_code, key_ext, key_brk, exp.code, exp.ext, exp.brk);
      end
    end
  endtask

  // Counts consecutive sampled cycles with rx_rst high, and rx_en violations within.
  task automatic count_rst(output int n, output int en_bad);
    n = 0;
    en_bad = 0;
    while (rx_rst === 1'b1 && n < 100) begin
      if (rx_en !== 1'b0) en_bad++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({rx_en, rx_rst, key_code, key_ext, key_brk, key_valid, overrun} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {rx_en, rx_rst, key_code, key_ext, key_brk, key_valid, overrun});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b1) begin
      failures++;
      $display("FAIL rx_en_after_reset: got %b, want 1", rx_en);
    end
  endtask

  task automatic test_make();
    sb.push_back('{8'h1C, 1'b0, 1'b0});
    send_byte(8'h1C, 1'b0);
    sb_pop("make_1c");
    do_ack();
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_clears: got valid=%b, want 0", key_valid);
    end
    sb.push_back('{8'h1C, 1'b1, 1'b0});
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1C, 1'b0);
    sb_pop("ext_make_1c");
    do_ack();
  endtask

  task automatic test_break();
    send_byte(8'hF0, 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL f0_no_event: got valid=%b, want 0", key_valid);
    end
    sb.push_back('{8'h1C, 1'b0, 1'b1});
    send_byte(8'h1C, 1'b0);
    sb_pop("brk_1c");
    do_ack();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL e0f0_no_event: got valid=%b, want 0", key_valid);
    end
    sb.push_back('{8'h75, 1'b1, 1'b1});
    send_byte(8'h75, 1'b0);
    sb_pop("ext_brk_75");
    do_ack();
  endtask

  task automatic test_timeout();
    int guard = 0;
    int n, en_bad;
    send_byte(8'hE0, 1'b0);
    while (rx_rst !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      failures++;
      $display("FAIL timeout_rx_rst: got rx_rst=%b after %0d cycles, want 1", rx_rst, guard);
    end
    count_rst(n, en_bad);
    checks++;
    if (n !== 16 || en_bad !== 0) begin
      failures++;
      $display("FAIL timeout_rst_len: got len=%0d en_bad=%0d, want len=16 en_bad=0", n, en_bad);
    end
    checks++;
    if (rx_en !== 1'b1 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after: got rx_en=%b valid=%b, want rx_en=1 valid=0", rx_en, key_valid);
    end
    sb.push_back('{8'h1C, 1'b0, 1'b0});
    send_byte(8'h1C, 1'b0);
    sb_pop("after_timeout_1c");
    do_ack();
  endtask

  task automatic test_overrun();
    apply_reset();
    sb.push_back('{8'h1C, 1'b0, 1'b0});
    send_byte(8'h1C, 1'b0);
    send_byte(8'h32, 1'b0);
    sb_pop("overrun_keeps_1c");
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    do_ack();
    apply_reset();
    sb.push_back('{8'h1C, 1'b0, 1'b0});
    send_byte(8'h1C, 1'b0);
    sb_pop("ack_same_1c");
    sb.push_back('{8'h32, 1'b0, 1'b0});
    send_byte(8'h32, 1'b1);
    sb_pop("ack_same_32");
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got %b, want 0", overrun);
    end
    do_ack();
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_after_32: got valid=%b, want 0", key_valid);
    end
  endtask

  task automatic test_ignored_and_err();
    int n, en_bad;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    checks++;
    if (key_valid !== 1'b0 || rx_rst !== 1'b0) begin
      failures++;
      $display("FAIL aa_fa_ignored: got valid=%b rx_rst=%b, want 0 0", key_valid, rx_rst);
    end
    send_byte(8'hFF, 1'b0);
    count_rst(n, en_bad);
    checks++;
    if (n !== 16 || en_bad !== 0 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL ff_recover: got len=%0d en_bad=%0d valid=%b, want 16 0 0", n, en_bad, key_valid);
    end
  endtask

  task automatic test_enable_drop();
    send_byte(8'hE0, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b0) begin
      failures++;
      $display("FAIL enable_low_rx_en: got %b, want 0", rx_en);
    end
    enable = 1'b1;
    @(negedge clk);
    sb.push_back('{8'h1C, 1'b0, 1'b0});
    send_byte(8'h1C, 1'b0);
    sb_pop("enable_prefix_discarded");
    do_ack();
  endtask

  task automatic test_async_reset();
    send_byte(8'hE0, 1'b0);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({rx_en, rx_rst, key_code, key_ext, key_brk, key_valid, overrun} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid_seq: got %b, want all zero",
               {rx_en, rx_rst, key_code, key_ext, key_brk, key_valid, overrun});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.push_back('{8'h1C, 1'b0, 1'b0});
    send_byte(8'h1C, 1'b0);
    sb_pop("after_reset_1c");
    do_ack();
    send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_rst !== 1'b1) begin
      failures++;
      $display("FAIL err00_recover: got rx_rst=%b, want 1", rx_rst);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rx_rst !== 1'b0 || rx_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_recover: got rx_rst=%b rx_en=%b, want 0 0", rx_rst, rx_en);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_rst !== 1'b0 || rx_en !== 1'b1) begin
      failures++;
      $display("FAIL after_recover_reset: got rx_rst=%b rx_en=%b, want 0 1", rx_rst, rx_en);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_timeout();
    test_overrun();
    test_ignored_and_err();
    test_enable_drop();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Sequencer sitting between the PS/2 byte receiver (ps2_rx) and downstream key logic. Drives the receiver's rx_en and reset, parses scan-code byte streams (E0 extended prefix, F0 break prefix) into single key events, and buffers one event behind a valid/ack handshake. An inter-byte watchdog and a recovery sequence replace free-running periodic receiver resets.

Parameters:
TIMEOUT_CYC, 5000000, max clk cycles allowed between prefix byte and following byte (100 ms at 50 MHz) before the sequence is aborted
RST_LEN, 16, clk cycles rx_rst is held high during recovery
CNT_W, 23, watchdog counter width; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low block reset
enable  in  1  1 = receive permitted; 0 = rx_en forced low, parser held in IDLE
rx_done_tick  in  1  one-cycle strobe from receiver, rx_dout valid
rx_dout  in  8  received byte
rx_en  out  1  receive enable to receiver
rx_rst  out  1  active-high synchronous reset to receiver
key_code  out  8  scan code of buffered event
key_ext  out  1  event was E0-prefixed
key_brk  out  1  event is a release (F0-prefixed)
key_valid  out  1  buffered event present; held until accepted
key_ack  in  1  consumer accepts event when key_valid=1
overrun  out  1  sticky: event lost because buffer was full

Behaviour:
- Reset (reset=0, async): state=IDLE, watchdog=0, rx_en=0, rx_rst=0, key_code=8'h00, key_ext=0, key_brk=0, key_valid=0, overrun=0. First clk after release: rx_en follows enable.
- States: IDLE, PRE_E0, PRE_F0, PRE_E0F0, RECOVER.
- rx_en = enable AND (state != RECOVER), registered.
- Byte handling (only on rx_done_tick=1):
  - IDLE: E0 -> PRE_E0; F0 -> PRE_F0; AA or FA -> ignored, stay; 00 or FF -> RECOVER; else emit {code, ext=0, brk=0}, stay.
  - PRE_E0: F0 -> PRE_E0F0; 00/FF -> RECOVER; else emit {code, ext=1, brk=0} -> IDLE.
  - PRE_F0: 00/FF/E0/F0 -> RECOVER; else emit {code, ext=0, brk=1} -> IDLE.
  - PRE_E0F0: 00/FF/E0/F0 -> RECOVER; else emit {code, ext=1, brk=1} -> IDLE.
  - RECOVER: bytes discarded.
- Emit latency: key_valid and key fields registered on the clk edge after the cycle rx_done_tick carries the final byte (1 cycle).
- Watchdog: cleared on every rx_done_tick and in IDLE; increments each cycle in PRE_* states; reaching TIMEOUT_CYC-1 -> RECOVER, nothing emitted.
- RECOVER: rx_rst=1 and rx_en=0 for exactly RST_LEN cycles (reuses watchdog counter), then IDLE with counter cleared. key_valid/buffer/overrun untouched.
- Handshake: emit with key_valid=0 -> load. Emit with key_valid=1 and key_ack=0 -> event dropped, overrun set. Emit with key_valid=1 and key_ack=1 same cycle -> new event loaded, key_valid stays 1, no overrun. key_ack with no emit -> key_valid cleared next edge. key_ack while key_valid=0 ignored.
- overrun clears only on reset.
- enable=0: parser forced to IDLE next edge, watchdog cleared, pending prefix discarded; buffered event and handshake keep operating; RECOVER in progress completes first.
- Async reset mid-sequence or mid-RECOVER: all state to reset values immediately; rx_rst drops asynchronously.

Decomposition:
- Package ps2_ctrl_pkg: state enum encoding; constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_ERR0=8'h00, SC_ERR1=8'hFF.
- One sub-module natural: ps2_event_buf (one-entry event register, valid/ack, overrun flag). Parser FSM and watchdog stay in top.

Test Plan:
- Bytes 1C -> one event key_code=1C ext=0 brk=0, key_valid 1 cycle after tick; ack clears it next edge.
- Bytes F0,1C then E0,F0,75 (acking between) -> {1C,ext0,brk1} then {75,ext1,brk1}; no event on prefixes.
- Byte E0 then no tick for TIMEOUT_CYC (override to 100) -> rx_rst high exactly 16 cycles, rx_en low same window, no event; next byte 1C emits ext=0.
- Two make codes 1C,32 without ack -> key_code stays 1C, overrun=1; repeat with key_ack asserted in 32's emit cycle -> key_code=32, overrun=0.
- Bytes AA, FA in IDLE -> no event; byte FF -> RECOVER sequence.
- Reset low after E0 mid-sequence, release, send 1C -> {1C,ext0,brk0}; all outputs zero during reset.
